// File: rtl/aib_sr_master_ml.sv
// Multi-lane sideband shift-register master: captures a synchronised core word,
// splits it across LANES serial lanes with optional even parity, and frames it with a LOAD strobe.
module aib_sr_master_ml #(
    parameter int                   SR_LENGTH   = 81,
    parameter int                   LANES       = 2,
    parameter int                   PARITY_EN   = 1,
    parameter int                   GAP         = 1,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [SR_LENGTH-1:0] RST_VAL     = '0
) (
    input  logic                 osc_clk,
    input  logic                 osc_fsm_ms_rstn,
    input  logic [SR_LENGTH-1:0] ms_data_fr_core,
    input  logic                 sr_mode,
    input  logic                 ms_frame_req,
    output logic [LANES-1:0]     sr_ms_data_out,
    output logic                 sr_ms_load_out,
    output logic                 ms_busy,
    output logic                 ms_frame_done
);

    localparam int CHUNK = (SR_LENGTH + LANES - 1) / LANES;
    localparam int PAR_W = (PARITY_EN != 0) ? 1 : 0;
    localparam int L     = CHUNK + PAR_W;
    localparam int CNT_W = $clog2(L + 1);
    localparam int PAD_W = CHUNK * LANES;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_GAP
    } state_t;

    logic [SR_LENGTH-1:0] sync_word;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_word = ms_data_fr_core;
        end else begin : g_sync
            logic [SR_LENGTH-1:0] sync_q [SYNC_STAGES];

            // NOTE: this array is a flop chain, not a RAM, so every stage takes the async reset value.
            always_ff @(posedge osc_clk or negedge osc_fsm_ms_rstn) begin
                if (!osc_fsm_ms_rstn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_VAL;
                end else begin
                    sync_q[0] <= ms_data_fr_core;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign sync_word = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [PAD_W-1:0] padded;
    logic [L-1:0]     lane_cap [LANES];

    // Lane k takes chunk k MSB-first; the parity bit rides last so the whole frame is even.
    always_comb begin
        padded                  = '0;
        padded[SR_LENGTH-1:0]   = sync_word;
        for (int k = 0; k < LANES; k++) begin
            lane_cap[k]                = '0;
            lane_cap[k][L-1 -: CHUNK]  = padded[k*CHUNK +: CHUNK];
            if (PAR_W == 1) lane_cap[k][0] = ^padded[k*CHUNK +: CHUNK];
        end
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;
    logic             pending;
    logic [L-1:0]     lane_q [LANES];
    logic             start_ok, boundary, capture;
    logic [LANES-1:0] data_w;
    logic             load_w;

    assign start_ok = !sr_mode || pending;

    // NOTE: every signal gets its default before the case, so no path can infer a latch;
    // blocking assignments here are combinational and the last one written wins.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gap_cnt_nxt = gap_cnt;
        boundary    = 1'b0;
        capture     = 1'b0;
        data_w      = '0;
        load_w      = 1'b0;
        unique case (state)
            ST_IDLE: boundary = 1'b1;
            ST_SHIFT: begin
                for (int k = 0; k < LANES; k++) data_w[k] = lane_q[k][L-1];
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_LOAD: begin
                load_w = 1'b1;
                if (GAP > 0) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                end else begin
                    boundary = 1'b1;
                end
            end
            ST_GAP: begin
                gap_cnt_nxt = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) boundary = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Frame boundary: the only place sr_mode and the pending request are looked at.
        if (boundary) begin
            if (start_ok) begin
                capture   = 1'b1;
                state_nxt = ST_SHIFT;
                cnt_nxt   = '0;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge osc_clk or negedge osc_fsm_ms_rstn) begin
        if (!osc_fsm_ms_rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            pending <= 1'b0;
            for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            pending <= ms_frame_req || (pending && !capture);
            for (int k = 0; k < LANES; k++) begin
                if (capture)                lane_q[k] <= lane_cap[k];
                else if (state == ST_SHIFT) lane_q[k] <= lane_q[k] << 1;
            end
        end
    end

    // Falling-edge retime keeps each bit stable across the partner's rising sample edge.
    always_ff @(negedge osc_clk or negedge osc_fsm_ms_rstn) begin
        if (!osc_fsm_ms_rstn) begin
            sr_ms_data_out <= '0;
            sr_ms_load_out <= 1'b0;
        end else begin
            sr_ms_data_out <= data_w;
            sr_ms_load_out <= load_w;
        end
    end

    assign ms_busy       = (state != ST_IDLE);
    assign ms_frame_done = (state == ST_LOAD);

endmodule
